ex_mem_wb_backend: RTL

- Back half of the 5-stage MIPS pipeline. Consumes the ID/EX register outputs and performs four jobs: EX (forwarding, ALU control, ALU), the EX/MEM register, MEM (data-memory port, beq resolution), and the MEM/WB register with write-back select.
- Drives the register-file write port (writeReg/writeData/RegWrite) back into the ID stage, closing the loop the ID stage reads from.

---
 rtl/mips_pkg.sv | 50 +++++
 rtl/mips_alu.sv | 32 +++
 rtl/ex_mem_wb_backend.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS back-end: instruction fields, ALUOp values
// and the internal ALU operation codes, plus the ALU-control decode.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_NONE  = 2'b11;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_ZERO = 4'b1111
    } alu_ctl_e;

    function automatic alu_ctl_e alu_decode(input logic [1:0] alu_op, input logic [5:0] funct);
        alu_ctl_e ctl;
        ctl = ALU_ZERO;
        if (alu_op == ALUOP_ADD) begin
            ctl = ALU_ADD;
        end else if (alu_op == ALUOP_SUB) begin
            ctl = ALU_SUB;
        end else if (alu_op == ALUOP_FUNCT) begin
            case (funct)
                FUNCT_ADD: ctl = ALU_ADD;
                FUNCT_SUB: ctl = ALU_SUB;
                FUNCT_AND: ctl = ALU_AND;
                FUNCT_OR:  ctl = ALU_OR;
                FUNCT_SLT: ctl = ALU_SLT;
                default:   ctl = ALU_ZERO;
            endcase
        end
        return ctl;
    endfunction

endpackage

// File: rtl/mips_alu.sv
// Combinational ALU control decode plus ALU; unknown operations yield 0.
module mips_alu
    import mips_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    input  logic [1:0]    i_alu_op,
    input  logic [5:0]    i_funct,
    output logic [DW-1:0] o_result,
    output logic          o_zero
);

    alu_ctl_e w_ctl;

    always_comb begin
        w_ctl    = alu_decode(i_alu_op, i_funct);
        o_result = '0;
        case (w_ctl)
            ALU_AND: o_result = i_a & i_b;
            ALU_OR:  o_result = i_a | i_b;
            ALU_ADD: o_result = i_a + i_b;
            ALU_SUB: o_result = i_a - i_b;
            ALU_SLT: o_result = {{(DW-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            default: o_result = '0;
        endcase
    end

    assign o_zero = (o_result == '0);

endmodule

// File: rtl/ex_mem_wb_backend.sv
// EX/MEM/WB half of the 5-stage MIPS pipeline: forwarding, ALU, EX/MEM and
// MEM/WB registers, data-memory port, beq resolution and write-back select.
module ex_mem_wb_backend
    import mips_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] id_pc,
    input  logic [DW-1:0] id_rd1,
    input  logic [DW-1:0] id_rd2,
    input  logic [DW-1:0] id_imm,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic [5:0]    id_funct,
    input  logic [1:0]    id_alu_op,
    input  logic          id_alu_src,
    input  logic          id_reg_dst,
    input  logic          id_branch,
    input  logic          id_mem_read,
    input  logic          id_mem_write,
    input  logic          id_reg_write,
    input  logic          id_mem_to_reg,
    input  logic          flush,
    output logic [DW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    output logic          dmem_we,
    output logic          dmem_re,
    input  logic [DW-1:0] dmem_rdata,
    output logic          branch_taken,
    output logic [DW-1:0] branch_target,
    output logic          ex_mem_read,
    output logic [RW-1:0] ex_rt,
    output logic [RW-1:0] wb_write_reg,
    output logic [DW-1:0] wb_write_data,
    output logic          wb_reg_write
);

    logic [DW-1:0] r_exmem_alu, r_exmem_store, r_exmem_target;
    logic [RW-1:0] r_exmem_dst;
    logic          r_exmem_zero, r_exmem_reg_write, r_exmem_mem_read;
    logic          r_exmem_mem_write, r_exmem_branch, r_exmem_mem_to_reg;

    logic [DW-1:0] r_memwb_alu, r_memwb_load;
    logic [RW-1:0] r_memwb_dst;
    logic          r_memwb_reg_write, r_memwb_mem_to_reg;

    logic [RW-1:0] w_src [2];
    logic [DW-1:0] w_id_val [2];
    logic [DW-1:0] w_fwd [2];
    logic [DW-1:0] w_alu_b, w_alu_result, w_target;
    logic [RW-1:0] w_dst;
    logic          w_alu_zero, w_squash;

    assign w_src[0]    = id_rs;
    assign w_src[1]    = id_rt;
    assign w_id_val[0] = id_rd1;
    assign w_id_val[1] = id_rd2;

    // Operand 0 is A (Rs), operand 1 is B (Rt); distance 1 beats distance 2.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            always_comb begin
                w_fwd[gi] = w_id_val[gi];
                if (r_exmem_reg_write && (r_exmem_dst != '0) && (r_exmem_dst == w_src[gi]))
                    w_fwd[gi] = r_exmem_alu;
                else if (r_memwb_reg_write && (r_memwb_dst != '0) && (r_memwb_dst == w_src[gi]))
                    w_fwd[gi] = wb_write_data;
            end
        end
    endgenerate

    assign w_alu_b  = id_alu_src ? id_imm : w_fwd[1];
    assign w_dst    = id_reg_dst ? id_rd : id_rt;
    assign w_target = id_pc + (id_imm << 2);

    mips_alu #(.DW(DW)) u_alu (
        .i_a      (w_fwd[0]),
        .i_b      (w_alu_b),
        .i_alu_op (id_alu_op),
        .i_funct  (id_funct),
        .o_result (w_alu_result),
        .o_zero   (w_alu_zero)
    );

    // A taken branch squashes the wrong-path instruction currently in EX.
    assign w_squash = flush | branch_taken;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_exmem_alu        <= '0;
            r_exmem_store      <= '0;
            r_exmem_target     <= '0;
            r_exmem_dst        <= '0;
            r_exmem_zero       <= 1'b0;
            r_exmem_reg_write  <= 1'b0;
            r_exmem_mem_read   <= 1'b0;
            r_exmem_mem_write  <= 1'b0;
            r_exmem_branch     <= 1'b0;
            r_exmem_mem_to_reg <= 1'b0;
        end else begin
            r_exmem_alu        <= w_alu_result;
            r_exmem_store      <= w_fwd[1];
            r_exmem_target     <= w_target;
            r_exmem_dst        <= w_dst;
            r_exmem_zero       <= w_alu_zero;
            r_exmem_reg_write  <= id_reg_write & ~w_squash;
            r_exmem_mem_read   <= id_mem_read  & ~w_squash;
            r_exmem_mem_write  <= id_mem_write & ~w_squash;
            r_exmem_branch     <= id_branch    & ~w_squash;
            r_exmem_mem_to_reg <= id_mem_to_reg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_memwb_alu        <= '0;
            r_memwb_load       <= '0;
            r_memwb_dst        <= '0;
            r_memwb_reg_write  <= 1'b0;
            r_memwb_mem_to_reg <= 1'b0;
        end else begin
            r_memwb_alu        <= r_exmem_alu;
            r_memwb_load       <= dmem_rdata;
            r_memwb_dst        <= r_exmem_dst;
            r_memwb_reg_write  <= r_exmem_reg_write;
            r_memwb_mem_to_reg <= r_exmem_mem_to_reg;
        end
    end

    assign dmem_addr     = r_exmem_alu;
    assign dmem_wdata    = r_exmem_store;
    assign dmem_we       = r_exmem_mem_write;
    assign dmem_re       = r_exmem_mem_read;
    assign branch_taken  = r_exmem_branch & r_exmem_zero;
    assign branch_target = r_exmem_target;

    assign ex_mem_read   = id_mem_read;
    assign ex_rt         = id_rt;

    assign wb_write_reg  = r_memwb_dst;
    assign wb_write_data = r_memwb_mem_to_reg ? r_memwb_load : r_memwb_alu;
    assign wb_reg_write  = r_memwb_reg_write;

endmodule
